// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave
//   AHB-lite responder for an on-chip word-organised SRAM. Accepts NONSEQ/SEQ
//   transfers, inserts WAIT_STATES wait cycles per OKAY transfer, performs
//   byte/halfword/word reads and writes, and gives the two-cycle ERROR response
//   for illegal size/alignment.
// Parameters:
//   ADDR_W      byte-address bits decoded here (memory = 2^(ADDR_W-2) words)
//   WAIT_STATES HREADYOUT-low cycles per OKAY transfer (0..15)
// Ports:
//   HCLK, HRESET             clock, asynchronous active-high reset
//   HSEL, HREADY             decoder select, bus-wide ready
//   HADDR, HTRANS, HWRITE,
//   HSIZE                    address-phase control
//   HBURST, HPROT,
//   HMASTCLOCK               accepted, ignored
//   HWDATA                   write data (data phase)
//   HRDATA, HREADYOUT, HRESP response to the slave-response multiplexer
module ahb_sram_slave #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic        HREADY,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic        HMASTCLOCK,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  localparam int unsigned DEPTH    = 1 << (ADDR_W - 2);
  localparam logic [3:0]  CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [1:0]          r_size;
  logic                r_write;
  logic [3:0]          r_cnt;
  logic [3:0]          w_cnt_next;
  logic                w_load;
  logic                w_accept;
  logic                w_illegal;
  logic [3:0]          w_be;
  logic [ADDR_W-3:0]   w_widx;
  logic [31:0]         r_mem [DEPTH];

  logic w_unused;
  assign w_unused = ^{HBURST, HPROT, HMASTCLOCK, HADDR[31:ADDR_W], HTRANS[0]};

  assign w_accept  = HSEL & HREADY & HTRANS[1];
  assign w_illegal = (HSIZE > 3'b010)
                   | ((HSIZE == 3'b001) & HADDR[0])
                   | ((HSIZE == 3'b010) & (HADDR[1:0] != 2'b00));

  // Next-state: IDLE, DATA and ERR2 are the cycles where the slave is ready,
  // so all three may accept a new address phase.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_load     = 1'b0;
    unique case (r_state)
      S_WAIT: begin
        if (r_cnt == 4'd0) w_next = S_DATA;
        else               w_cnt_next = r_cnt - 4'd1;
      end
      S_ERR1: w_next = S_ERR2;
      default: begin
        w_next = S_IDLE;
        if (w_accept) begin
          w_load = 1'b1;
          if (w_illegal) begin
            w_next = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            w_next     = S_WAIT;
            w_cnt_next = CNT_LOAD;
          end else begin
            w_next = S_DATA;
          end
        end
      end
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_size  <= '0;
      r_write <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_load) begin
        r_addr  <= HADDR[ADDR_W-1:0];
        r_size  <= HSIZE[1:0];
        r_write <= HWRITE;
      end
    end
  end

  assign w_widx = r_addr[ADDR_W-1:2];

  // Little-endian lane enables from the registered size and low address bits.
  always_comb begin
    w_be = 4'b0000;
    unique case (r_size)
      2'b00:   w_be = 4'b0001 << r_addr[1:0];
      2'b01:   w_be = r_addr[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  // Memory has no reset; an in-flight write is dropped because reset forces
  // the state out of DATA before the closing edge.
  always_ff @(posedge HCLK) begin
    if ((r_state == S_DATA) && r_write) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_widx][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

  assign HREADYOUT = (r_state != S_WAIT) && (r_state != S_ERR1);
  assign HRESP     = (r_state == S_ERR1) || (r_state == S_ERR2);
  assign HRDATA    = ((r_state == S_DATA) && !r_write) ? r_mem[w_widx] : '0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
module tb_ahb_sram_slave;

  localparam int unsigned AW     = 10;
  localparam int          NWORDS = 16;
  localparam int          BUDGET = 2000;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        hr_low;
  } xfer_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel;
  logic        force_low;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  int          cur;
  logic [2:0]  rdy;
  logic [2:0]  rsp;
  logic [31:0] rdat [3];
  logic [2:0]  hs_i;
  logic [2:0]  hr_i;
  int          ws_of [3] = '{0, 2, 3};
  logic [31:0] mem_m [3][256];
  xfer_t       q[$];
  int          n_total = 0;
  int          n_bad   = 0;

  always #5 clk = ~clk;

  always_comb begin
    hs_i = '0;
    hr_i = '0;
    for (int k = 0; k < 3; k++) begin
      hs_i[k] = hsel && (cur == k);
      hr_i[k] = rdy[k] && !force_low;
    end
  end

  ahb_sram_slave #(.ADDR_W(AW), .WAIT_STATES(0)) u_ws0 (
    .HCLK(clk), .HRESET(rst), .HSEL(hs_i[0]), .HREADY(hr_i[0]), .HADDR(haddr),
    .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b000), .HPROT(4'b0011),
    .HMASTCLOCK(1'b0), .HWDATA(hwdata), .HRDATA(rdat[0]), .HREADYOUT(rdy[0]), .HRESP(rsp[0]));

  ahb_sram_slave #(.ADDR_W(AW), .WAIT_STATES(2)) u_ws2 (
    .HCLK(clk), .HRESET(rst), .HSEL(hs_i[1]), .HREADY(hr_i[1]), .HADDR(haddr),
    .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b000), .HPROT(4'b0011),
    .HMASTCLOCK(1'b0), .HWDATA(hwdata), .HRDATA(rdat[1]), .HREADYOUT(rdy[1]), .HRESP(rsp[1]));

  ahb_sram_slave #(.ADDR_W(AW), .WAIT_STATES(3)) u_ws3 (
    .HCLK(clk), .HRESET(rst), .HSEL(hs_i[2]), .HREADY(hr_i[2]), .HADDR(haddr),
    .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b000), .HPROT(4'b0011),
    .HMASTCLOCK(1'b0), .HWDATA(hwdata), .HRDATA(rdat[2]), .HREADYOUT(rdy[2]), .HRESP(rsp[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s (dut%0d) got=%h exp=%h at %0t", tag, cur, got, exp, $time);
    end
  endtask

  function automatic bit is_legal(input logic [2:0] sz, input logic [31:0] ad);
    if (sz > 3'd2) return 1'b0;
    return (ad % (32'd1 << sz)) == 32'd0;
  endfunction

  // Reference write: bytes [addr%4, addr%4 + 2^size) of the word take new data.
  task automatic model_write(input xfer_t x);
    int unsigned st;
    int unsigned nb;
    int unsigned wi;
    st = x.addr % 4;
    nb = 1 << x.size;
    wi = (x.addr % (1 << AW)) / 4;
    for (int unsigned b = st; b < st + nb; b++)
      mem_m[cur][wi][8*b +: 8] = x.wdata[8*b +: 8];
  endtask

  task automatic push(input logic sel, input logic [1:0] tr, input logic wr,
                      input logic [2:0] sz, input logic [31:0] ad,
                      input logic [31:0] wd, input logic hl);
    xfer_t x;
    x.sel = sel; x.trans = tr; x.wr = wr; x.size = sz;
    x.addr = ad; x.wdata = wd; x.hr_low = hl;
    q.push_back(x);
  endtask

  // Pipelined master: address of the next transfer overlaps the data phase of
  // the previous one; every cycle's response is checked against the model.
  task automatic run_q();
    bit          d_valid = 0;
    xfer_t       d;
    xfer_t       a;
    int          d_cyc = 0;
    int          idx = 0;
    int          budget = 0;
    logic        s_rdy;
    logic        e_rdy;
    logic        e_rsp;
    logic [31:0] e_rd;
    d.sel = 0; d.trans = 0; d.wr = 0; d.size = 0; d.addr = 0; d.wdata = 0; d.hr_low = 0;
    while ((idx < q.size() || d_valid) && budget < BUDGET) begin
      if (idx < q.size()) a = q[idx];
      else begin
        a.sel = 0; a.trans = 2'b00; a.wr = 0; a.size = 0;
        a.addr = '0; a.wdata = '0; a.hr_low = 0;
      end
      hsel = a.sel; htrans = a.trans; hwrite = a.wr; hsize = a.size;
      haddr = a.addr; force_low = a.hr_low;
      hwdata = d_valid ? d.wdata : $urandom();
      @(negedge clk);
      e_rdy = 1'b1; e_rsp = 1'b0; e_rd = '0;
      if (d_valid) begin
        if (is_legal(d.size, d.addr)) begin
          e_rdy = (d_cyc == ws_of[cur]);
          if (e_rdy && !d.wr) e_rd = mem_m[cur][(d.addr % (1 << AW)) / 4];
        end else begin
          e_rdy = (d_cyc == 1);
          e_rsp = 1'b1;
        end
      end
      chk("hreadyout", 32'(rdy[cur]), 32'(e_rdy));
      chk("hresp", 32'(rsp[cur]), 32'(e_rsp));
      chk("hrdata", rdat[cur], e_rd);
      s_rdy = rdy[cur];
      @(posedge clk);
      if (s_rdy) begin
        if (d_valid && is_legal(d.size, d.addr) && d.wr) model_write(d);
        d_valid = (idx < q.size()) && a.sel && a.trans[1] && !a.hr_low;
        d = a;
        d_cyc = 0;
        if (idx < q.size()) idx++;
      end else begin
        d_cyc++;
      end
      #1;
      budget++;
    end
    chk("drain", 32'(q.size() - idx) + 32'(d_valid), 32'd0);
    q.delete();
    hsel = 0; htrans = 2'b00; force_low = 0;
  endtask

  task automatic gen_rand(input int n);
    for (int i = 0; i < n; i++) begin
      int          kind;
      logic [31:0] up;
      logic [31:0] lo;
      logic [2:0]  sz;
      kind = $urandom_range(0, 9);
      up   = $urandom() << AW;
      lo   = 32'($urandom_range(0, NWORDS * 4 - 1));
      sz   = 3'($urandom_range(0, 2));
      case (kind)
        0: push(1, 2'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'd2, up | (lo & ~32'd3), $urandom(), 0);
        1: push(0, 2'b10, 1, 3'd2, up | (lo & ~32'd3), $urandom(), 0);
        2: begin
          if ($urandom_range(0, 1) == 0) begin
            sz = 3'($urandom_range(3, 7));
          end else begin
            sz = 3'($urandom_range(1, 2));
            lo = (lo & ~32'd3) | ((sz == 3'd2) ? 32'($urandom_range(1, 3))
                                               : 32'($urandom_range(0, 1) * 2 + 1));
          end
          push(1, 2'($urandom_range(2, 3)), 1'($urandom_range(0, 1)), sz, up | lo, $urandom(), 0);
        end
        3: push(1, 2'b10, 1, 3'd2, up | (lo & ~32'd3), $urandom(), 1);
        default: push(1, 2'($urandom_range(2, 3)), 1'($urandom_range(0, 1)), sz,
                      up | (lo & ~((32'd1 << sz) - 1)), $urandom(), 0);
      endcase
    end
  endtask

  initial begin
    logic [31:0] w;
    rst = 1; hsel = 0; htrans = 0; hwrite = 0; hsize = 0; haddr = 0; hwdata = 0;
    force_low = 0; cur = 0;
    #12;
    for (int k = 0; k < 3; k++) begin
      cur = k;
      chk("rst_hreadyout", 32'(rdy[k]), 32'd1);
      chk("rst_hresp", 32'(rsp[k]), 32'd0);
      chk("rst_hrdata", rdat[k], 32'd0);
    end
    @(negedge clk); rst = 0;
    @(posedge clk); #1;

    for (int k = 0; k < 3; k++) begin
      cur = k;
      for (int i = 0; i < NWORDS + 1; i++) push(1, 2'b10, 1, 3'd2, 32'(i * 4), $urandom(), 0);
      run_q();
    end

    // Zero wait states: write then read back-to-back.
    cur = 0;
    push(1, 2'b10, 1, 3'd2, 32'h10, 32'hDEADBEEF, 0);
    push(1, 2'b10, 0, 3'd2, 32'h10, 32'h0, 0);
    run_q();

    // Two wait states: read with a pipelined NONSEQ behind it, then lane merges.
    cur = 1;
    push(1, 2'b10, 1, 3'd2, 32'h10, 32'hDEADBEEF, 0);
    push(1, 2'b10, 0, 3'd2, 32'h10, 32'h0, 0);
    push(1, 2'b10, 0, 3'd2, 32'h14, 32'h0, 0);
    w = $urandom(); w[23:16] = 8'h55;
    push(1, 2'b10, 1, 3'd0, 32'h12, w, 0);
    w = $urandom(); w[15:0] = 16'hA1B2;
    push(1, 2'b11, 1, 3'd1, 32'h14, w, 0);
    push(1, 2'b10, 0, 3'd2, 32'h10, 32'h0, 0);
    push(1, 2'b10, 0, 3'd2, 32'h14, 32'h0, 0);
    // Illegal accesses, then non-transfers, then confirm memory untouched.
    push(1, 2'b10, 1, 3'd2, 32'h11, 32'h12345678, 0);
    push(1, 2'b10, 1, 3'd3, 32'h20, 32'h12345678, 0);
    push(1, 2'b10, 0, 3'd2, 32'h10, 32'h0, 0);
    push(1, 2'b00, 1, 3'd2, 32'h10, 32'h0, 0);
    push(1, 2'b01, 1, 3'd2, 32'h10, 32'h0, 0);
    push(0, 2'b10, 1, 3'd2, 32'h10, 32'h0, 0);
    push(1, 2'b10, 1, 3'd2, 32'h10, 32'h0, 1);
    push(1, 2'b10, 0, 3'd2, 32'h10, 32'h0, 0);
    run_q();

    for (int k = 0; k < 3; k++) begin
      cur = k;
      gen_rand(60);
      run_q();
    end

    // Reset during the second wait cycle of a write must drop that write.
    cur = 2;
    push(1, 2'b10, 1, 3'd2, 32'h40, 32'h11223344, 0);
    run_q();
    hsel = 1; htrans = 2'b10; hwrite = 1; hsize = 3'd2; haddr = 32'h40;
    @(posedge clk); #1;
    hsel = 0; htrans = 2'b00; hwdata = 32'hAABBCCDD;
    @(posedge clk); #1;
    chk("pre_rst_hreadyout", 32'(rdy[2]), 32'd0);
    rst = 1; #1;
    chk("async_rst_hreadyout", 32'(rdy[2]), 32'd1);
    chk("async_rst_hresp", 32'(rsp[2]), 32'd0);
    chk("async_rst_hrdata", rdat[2], 32'd0);
    @(posedge clk); @(negedge clk); rst = 0;
    @(posedge clk); #1;
    push(1, 2'b10, 0, 3'd2, 32'h40, 32'h0, 0);
    push(1, 2'b10, 1, 3'd1, 32'h42, 32'h5A5A0000, 0);
    push(1, 2'b10, 0, 3'd2, 32'h40, 32'h0, 0);
    run_q();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
